axi_lite_reg_bridge: RTL and testbench

- AXI4-Lite slave that converts bus transactions into a simple one-transaction-at-a-time register strobe interface for the accelerator's register file.
- Write path: address and data are captured, the user logic gets a one-cycle "data ready" strobe, and the bridge waits for an acknowledge strobe before sending the B response.
- Read path: a one-cycle "read request" strobe is issued, the bridge waits for a ready strobe with data, then returns the R response.
- No write strobes (byte enables), no bursts, and no outstanding transactions.

---
 rtl/axi_lite_reg_bridge_if.sv | 25 ++
 rtl/axi_lite_reg_bridge.sv | 93 +++++++++
 tb/tb_axi_lite_reg_bridge.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_bridge_if.sv
// axi_lite_reg_bridge_if: AXI4-Lite bus bundle (no WSTRB/PROT) shared by master and slave.
interface axi_lite_reg_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  awvalid, awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid, wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  bvalid, bready;
  logic [1:0]            bresp;
  logic                  arvalid, arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid, rready;
  logic [1:0]            rresp;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// axi_lite_reg_bridge: AXI4-Lite slave turning bus transactions into one-at-a-time register strobes.
module axi_lite_reg_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_reg_bridge_if.slave  s_axi,
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  input  logic                  i_reg_invalid_addr,
  output logic                  o_reg_in_rdy,
  input  logic                  i_reg_in_ack_stb,
  output logic [DATA_WIDTH-1:0] o_reg_in_data,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy_stb,
  input  logic [DATA_WIDTH-1:0] i_reg_out_data
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_WAIT = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  logic [2:0] state;
  logic       aw_f, w_f;
  logic       idle, aw_hs, w_hs, ar_hs, aw_nx, w_nx;
  // readies are gated by rst so every output reads 0 while held in reset
  assign idle          = rst && state == IDLE;
  assign s_axi.awready = idle && !aw_f;
  assign s_axi.wready  = idle && !w_f;
  assign s_axi.arready = idle && !aw_f && !w_f && !s_axi.awvalid && !s_axi.wvalid;
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign aw_nx = aw_f || aw_hs;
  assign w_nx  = w_f || w_hs;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      aw_f          <= 1'b0;
      w_f           <= 1'b0;
      o_reg_address <= '0;
      o_reg_in_data <= '0;
      o_reg_in_rdy  <= 1'b0;
      o_reg_out_req <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= 2'b00;
      s_axi.rdata   <= '0;
    end else begin
      o_reg_in_rdy  <= 1'b0;
      o_reg_out_req <= 1'b0;
      case (state)
        IDLE: begin
          if (aw_hs) o_reg_address <= s_axi.awaddr;
          if (w_hs) o_reg_in_data <= s_axi.wdata;
          aw_f <= aw_nx;
          w_f  <= w_nx;
          if (aw_nx && w_nx) begin
            state        <= WR_WAIT;
            o_reg_in_rdy <= 1'b1;
          end else if (ar_hs) begin
            o_reg_address <= s_axi.araddr;
            state         <= RD_WAIT;
            o_reg_out_req <= 1'b1;
          end
        end
        WR_WAIT: if (i_reg_in_ack_stb) begin
          s_axi.bresp  <= i_reg_invalid_addr ? 2'b10 : 2'b00;
          s_axi.bvalid <= 1'b1;
          aw_f         <= 1'b0;
          w_f          <= 1'b0;
          state        <= WR_RESP;
        end
        WR_RESP: if (s_axi.bready) begin
          s_axi.bvalid <= 1'b0;
          state        <= IDLE;
        end
        RD_WAIT: if (i_reg_out_rdy_stb) begin
          s_axi.rdata  <= i_reg_out_data;
          s_axi.rresp  <= i_reg_invalid_addr ? 2'b10 : 2'b00;
          s_axi.rvalid <= 1'b1;
          state        <= RD_RESP;
        end
        RD_RESP: if (s_axi.rready) begin
          s_axi.rvalid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// tb_axi_lite_reg_bridge: directed checks of write/read paths, priority and async reset.
module tb_axi_lite_reg_bridge;
  logic        clk, rst;
  logic [15:0] reg_address;
  logic        reg_invalid_addr, reg_in_rdy, reg_in_ack_stb, reg_out_req, reg_out_rdy_stb;
  logic [31:0] reg_in_data, reg_out_data;
  int          n_cmp = 0, n_err = 0;
  axi_lite_reg_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
  axi_lite_reg_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s_axi(bus),
    .o_reg_address(reg_address), .i_reg_invalid_addr(reg_invalid_addr),
    .o_reg_in_rdy(reg_in_rdy), .i_reg_in_ack_stb(reg_in_ack_stb), .o_reg_in_data(reg_in_data),
    .o_reg_out_req(reg_out_req), .i_reg_out_rdy_stb(reg_out_rdy_stb), .i_reg_out_data(reg_out_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_start(input logic [15:0] a, input logic [31:0] d);
    bus.awvalid = 1'b1; bus.awaddr = a; bus.wvalid = 1'b1; bus.wdata = d;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("wr_rdy", reg_in_rdy, 1);
    chk("wr_addr", reg_address, a);
    chk("wr_data", reg_in_data, d);
  endtask
  task automatic wr_resp(input logic inv, input logic [1:0] exp_resp, input int hold);
    reg_in_ack_stb = 1'b1; reg_invalid_addr = inv;
    tick();
    reg_in_ack_stb = 1'b0; reg_invalid_addr = 1'b0;
    chk("bvalid", bus.bvalid, 1);
    chk("bresp", bus.bresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bvalid_hold", bus.bvalid, 1);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("bvalid_drop", bus.bvalid, 0);
  endtask
  task automatic rd_start(input logic [15:0] a);
    bus.arvalid = 1'b1; bus.araddr = a;
    #1 chk("arready", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    chk("rd_req", reg_out_req, 1);
    chk("rd_addr", reg_address, a);
    tick();
    chk("rd_req_pulse", reg_out_req, 0);
  endtask
  task automatic rd_resp(input logic [31:0] d, input logic inv, input logic [31:0] exp_d,
                         input logic [1:0] exp_resp, input int hold);
    reg_out_rdy_stb = 1'b1; reg_out_data = d; reg_invalid_addr = inv;
    tick();
    reg_out_rdy_stb = 1'b0; reg_out_data = '0; reg_invalid_addr = 1'b0;
    chk("rvalid", bus.rvalid, 1);
    chk("rdata", bus.rdata, exp_d);
    chk("rresp", bus.rresp, exp_resp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rvalid_hold", bus.rvalid, 1);
      chk("rdata_hold", bus.rdata, exp_d);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("rvalid_drop", bus.rvalid, 0);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_bvalid"}, bus.bvalid, 0);
    chk({tag, "_rvalid"}, bus.rvalid, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_rresp"}, bus.rresp, 0);
    chk({tag, "_bresp"}, bus.bresp, 0);
    chk({tag, "_addr"}, reg_address, 0);
    chk({tag, "_wdata"}, reg_in_data, 0);
    chk({tag, "_in_rdy"}, reg_in_rdy, 0);
    chk({tag, "_out_req"}, reg_out_req, 0);
    chk({tag, "_readies"}, {bus.awready, bus.wready, bus.arready}, 0);
  endtask
  initial begin
    rst = 1'b0;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    reg_invalid_addr = 0; reg_in_ack_stb = 0; reg_out_rdy_stb = 0; reg_out_data = '0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b1;
    tick();
    bus.awvalid = 1'b1; bus.awaddr = 16'h0008; bus.wvalid = 1'b1; bus.wdata = 32'h0000_0FA0;
    #1 chk("awready_idle", bus.awready, 1);
    chk("wready_idle", bus.wready, 1);
    wr_start(16'h0008, 32'h0000_0FA0);
    chk("awready_busy", bus.awready, 0);
    tick();
    chk("in_rdy_pulse", reg_in_rdy, 0);
    wr_resp(1'b0, 2'b00, 3);
    bus.wvalid = 1'b1; bus.wdata = 32'h0000_1234;
    tick();
    bus.wvalid = 1'b0;
    chk("w_first_wready", bus.wready, 0);
    chk("w_first_rdy0", reg_in_rdy, 0);
    tick();
    chk("w_first_rdy1", reg_in_rdy, 0);
    bus.awvalid = 1'b1; bus.awaddr = 16'h0000;
    tick();
    bus.awvalid = 1'b0;
    chk("w_first_rdy", reg_in_rdy, 1);
    chk("w_first_addr", reg_address, 16'h0000);
    chk("w_first_data", reg_in_data, 32'h0000_1234);
    tick();
    chk("w_first_pulse", reg_in_rdy, 0);
    wr_resp(1'b0, 2'b00, 0);
    reg_in_ack_stb = 1'b1; reg_out_rdy_stb = 1'b1;
    tick();
    reg_in_ack_stb = 1'b0; reg_out_rdy_stb = 1'b0;
    chk("idle_ack_ignored", bus.bvalid, 0);
    chk("idle_rdy_ignored", bus.rvalid, 0);
    rd_start(16'h0010);
    rd_resp(32'h0CA7_CAFE, 1'b0, 32'h0CA7_CAFE, 2'b00, 2);
    rd_start(16'h001C);
    rd_resp(32'h0000_0000, 1'b1, 32'h0000_0000, 2'b10, 0);
    wr_start(16'h0020, 32'h0000_0055);
    wr_resp(1'b1, 2'b10, 0);
    bus.arvalid = 1'b1; bus.araddr = 16'h0030;
    bus.awvalid = 1'b1; bus.awaddr = 16'h0024; bus.wvalid = 1'b1; bus.wdata = 32'h0000_00AB;
    #1 chk("prio_arready0", bus.arready, 0);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("prio_wr_rdy", reg_in_rdy, 1);
    chk("prio_wr_addr", reg_address, 16'h0024);
    chk("prio_arready1", bus.arready, 0);
    chk("prio_no_req", reg_out_req, 0);
    reg_in_ack_stb = 1'b1;
    tick();
    reg_in_ack_stb = 1'b0;
    chk("prio_bvalid", bus.bvalid, 1);
    chk("prio_arready2", bus.arready, 0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("prio_bdrop", bus.bvalid, 0);
    chk("prio_arready_idle", bus.arready, 1);
    tick();
    bus.arvalid = 1'b0;
    chk("prio_rd_req", reg_out_req, 1);
    chk("prio_rd_addr", reg_address, 16'h0030);
    rd_resp(32'h0000_0077, 1'b0, 32'h0000_0077, 2'b00, 0);
    wr_start(16'h0040, 32'h0000_0099);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_wr_wait");
    rst = 1'b1;
    tick();
    rd_start(16'h0044);
    reg_out_rdy_stb = 1'b1; reg_out_data = 32'h0000_DEAD;
    tick();
    reg_out_rdy_stb = 1'b0; reg_out_data = '0;
    chk("rst_rd_rvalid", bus.rvalid, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_rd_resp");
    rst = 1'b1;
    tick();
    chk("post_rst_bvalid", bus.bvalid, 0);
    wr_start(16'h0048, 32'h0000_1111);
    tick();
    chk("post_rst_no_b", bus.bvalid, 0);
    wr_resp(1'b0, 2'b00, 0);
    chk("post_rst_no_r", bus.rvalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
